// File: rtl/blockstacker_pkg.sv
// Shared definitions for the block stacker: checker state encoding and
// default geometry of the block-plot pixel stream.
package blockstacker_pkg;

    localparam int DEF_BLOCK_SIZE = 4;
    localparam int DEF_X_W        = 8;
    localparam int DEF_Y_W        = 7;
    localparam int DEF_C_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/block_pixel_counter.sv
// Raster position (cx, cy) of the next expected pixel inside a block;
// same walk as the draw-side pixel counter.
module block_pixel_counter #(
    parameter int BLOCK_SIZE = 4,
    localparam int CNT_W = $clog2(BLOCK_SIZE)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             load,
    input  logic             enable,
    output logic [CNT_W-1:0] cx,
    output logic [CNT_W-1:0] cy,
    output logic             last
);

    // BLOCK_SIZE is a power of two, so natural wrap gives the modulo.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cx <= '0;
            cy <= '0;
        end else if (clear) begin
            cx <= '0;
            cy <= '0;
        end else if (load) begin
            cx <= CNT_W'(1);
            cy <= '0;
        end else if (enable) begin
            cx <= cx + 1'b1;
            if (&cx) cy <= cy + 1'b1;
        end
    end

    assign last = (&cx) && (&cy);

endmodule

// File: rtl/block_plot_checker.sv
// Reassembles the per-block pixel stream into one block record, checks raster
// order and colour, and offers the record with its overlap against the previous block.
module block_plot_checker
    import blockstacker_pkg::*;
#(
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int C_W        = DEF_C_W
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           plot,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic [C_W-1:0] colour_in,
    input  logic           blk_ack,
    output logic           blk_valid,
    output logic [X_W-1:0] blk_x,
    output logic [Y_W-1:0] blk_y,
    output logic [C_W-1:0] blk_colour,
    output logic           blk_error,
    output logic [X_W-1:0] ovl_start,
    output logic [X_W-1:0] ovl_end,
    output logic           ovl_none,
    output logic           busy,
    output logic           overrun
);

    localparam int CNT_W = $clog2(BLOCK_SIZE);
    localparam logic [X_W:0] X_LIM = (X_W+1)'((1 << X_W) - BLOCK_SIZE);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'((1 << Y_W) - BLOCK_SIZE);
    localparam logic [X_W:0] BS_M1 = (X_W+1)'(BLOCK_SIZE - 1);

    state_t state, state_nx;

    logic [X_W-1:0]   org_x, prev_x;
    logic [Y_W-1:0]   org_y;
    logic [C_W-1:0]   colour_q;
    logic             err, valid_q, prev_valid, overrun_q;
    logic [CNT_W-1:0] cx, cy;
    logic             last;
    logic             capture, check, finish, accept, drop, cnt_clear;
    logic             edge_err, pix_bad;

    block_pixel_counter #(.BLOCK_SIZE(BLOCK_SIZE)) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clear  (cnt_clear),
        .load   (capture),
        .enable (check),
        .cx     (cx),
        .cy     (cy),
        .last   (last)
    );

    // The origin alone decides whether the block would run off the screen edge.
    assign edge_err = ({1'b0, x_in} > X_LIM) || ({1'b0, y_in} > Y_LIM);
    assign pix_bad  = (x_in != org_x + X_W'(cx)) || (y_in != org_y + Y_W'(cy)) ||
                      (colour_in != colour_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        capture   = 1'b0;
        check     = 1'b0;
        finish    = 1'b0;
        accept    = 1'b0;
        drop      = 1'b0;
        cnt_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                if (plot) begin
                    capture  = 1'b1;
                    state_nx = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (plot) begin
                    check = 1'b1;
                    if (last) begin
                        finish   = 1'b1;
                        state_nx = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (blk_ack) begin
                    accept = 1'b1;
                    if (plot) begin
                        capture  = 1'b1;
                        state_nx = ST_COLLECT;
                    end else begin
                        cnt_clear = 1'b1;
                        state_nx  = ST_IDLE;
                    end
                end else if (plot) begin
                    drop = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            org_x      <= '0;
            org_y      <= '0;
            colour_q   <= '0;
            err        <= 1'b0;
            valid_q    <= 1'b0;
            prev_x     <= '0;
            prev_valid <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= drop;
            if (capture) begin
                org_x    <= x_in;
                org_y    <= y_in;
                colour_q <= colour_in;
                err      <= edge_err;
            end else if (check && pix_bad) begin
                err <= 1'b1;
            end
            if (finish)      valid_q <= 1'b1;
            else if (accept) valid_q <= 1'b0;
            if (accept) begin
                prev_x     <= org_x;
                prev_valid <= 1'b1;
            end
        end
    end

    logic [X_W:0] bx, px, lo, hi;

    // Overlap at X_W+1 bits so a block at the right edge does not wrap.
    always_comb begin
        bx        = {1'b0, org_x};
        px        = {1'b0, prev_x};
        lo        = (bx > px) ? bx : px;
        hi        = ((bx < px) ? bx : px) + BS_M1;
        ovl_start = '0;
        ovl_end   = '0;
        ovl_none  = 1'b0;
        if (valid_q) begin
            if (!prev_valid) begin
                ovl_start = org_x;
                ovl_end   = org_x + X_W'(BLOCK_SIZE - 1);
            end else begin
                ovl_start = lo[X_W-1:0];
                ovl_end   = hi[X_W-1:0];
                ovl_none  = (lo > hi);
            end
        end
    end

    assign blk_valid  = valid_q;
    assign blk_x      = org_x;
    assign blk_y      = org_y;
    assign blk_colour = colour_q;
    assign blk_error  = err;
    assign busy       = (state != ST_IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_block_plot_checker.sv
// Bench for block_plot_checker: fixed vector table, hand sequences for
// backpressure and reset, then random blocks against a pixel-list model.
module tb_block_plot_checker;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       plot = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [2:0] colour_in = '0;
    logic       blk_ack = 1'b0;
    logic       blk_valid, blk_error, ovl_none, busy, overrun;
    logic [7:0] blk_x, ovl_start, ovl_end;
    logic [6:0] blk_y;
    logic [2:0] blk_colour;

    block_plot_checker dut (
        .clk(clk), .resetn(resetn), .plot(plot), .x_in(x_in), .y_in(y_in),
        .colour_in(colour_in), .blk_ack(blk_ack), .blk_valid(blk_valid),
        .blk_x(blk_x), .blk_y(blk_y), .blk_colour(blk_colour), .blk_error(blk_error),
        .ovl_start(ovl_start), .ovl_end(ovl_end), .ovl_none(ovl_none),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pv = 0;
    int pxv = 0;
    int dx[16];
    int dy[16];
    int dc[16];

    typedef struct {
        int ox, oy, col, fault, fidx;
        int err, os, oe, on;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // fault: 1 wrong colour, 2 x off by one, 3 y off by one, at pixel fidx
    task automatic drive_block(input int ox, input int oy, input int col, input int fault,
                               input int fidx, input int first, input bit gaps);
        for (int i = first; i < 16; i++) begin
            int x, y, c, g;
            x = (ox + i % 4) % 256;
            y = (oy + i / 4) % 128;
            c = col;
            if (i == fidx && fault == 1) c = (col == 1) ? 2 : 1;
            if (i == fidx && fault == 2) x = (x + 1) % 256;
            if (i == fidx && fault == 3) y = (y + 1) % 128;
            g = gaps ? $urandom_range(0, 2) : 0;
            if (g > 0) begin
                plot = 1'b0;
                repeat (g) step();
            end
            dx[i] = x; dy[i] = y; dc[i] = c;
            plot = 1'b1; x_in = x[7:0]; y_in = y[6:0]; colour_in = c[2:0];
            step();
        end
        plot = 1'b0;
    endtask

    function automatic int model_err(input int ox, input int oy);
        int e;
        e = (ox > 256 - 4 || oy > 128 - 4) ? 1 : 0;
        for (int i = 1; i < 16; i++)
            if (dx[i] != (ox + i % 4) % 256 || dy[i] != (oy + i / 4) % 128 || dc[i] != dc[0])
                e = 1;
        return e;
    endfunction

    task automatic model_ovl(input int bx, output int s, output int e, output int n);
        int lo, hi;
        if (pv == 0) begin
            s = bx; e = (bx + 3) % 256; n = 0;
        end else begin
            lo = (bx > pxv) ? bx : pxv;
            hi = ((bx < pxv) ? bx : pxv) + 3;
            s = lo; e = hi % 256; n = (lo > hi) ? 1 : 0;
        end
    endtask

    task automatic check_block(input string tag, input int ox, input int oy, input int col,
                               input int err, input int s, input int e, input int n);
        chk({tag, ".valid"},  blk_valid, 1);
        chk({tag, ".x"},      blk_x, ox);
        chk({tag, ".y"},      blk_y, oy);
        chk({tag, ".colour"}, blk_colour, col);
        chk({tag, ".error"},  blk_error, err);
        chk({tag, ".ostart"}, ovl_start, s);
        chk({tag, ".oend"},   ovl_end, e);
        chk({tag, ".onone"},  ovl_none, n);
    endtask

    task automatic accept(input int ox);
        blk_ack = 1'b1;
        step();
        blk_ack = 1'b0;
        pv = 1; pxv = ox;
        chk("accept.valid", blk_valid, 0);
        chk("accept.busy", busy, 0);
    endtask

    initial begin
        int s, e, n, ox, oy, col, fault, fidx, hold;
        tbl[0] = '{20, 10, 5, 0, 0,   0, 20, 23, 0};
        tbl[1] = '{22, 10, 5, 0, 0,   0, 22, 23, 0};
        tbl[2] = '{30, 10, 5, 0, 0,   0, 30, 25, 1};
        tbl[3] = '{40, 20, 5, 1, 6,   1, 40, 33, 1};
        tbl[4] = '{40, 20, 3, 2, 9,   1, 40, 43, 0};
        tbl[5] = '{253, 0, 1, 0, 0,   1, 253, 43, 1};
        tbl[6] = '{252, 0, 1, 0, 0,   0, 253, 255, 0};
        tbl[7] = '{0, 124, 2, 0, 0,   0, 252, 3, 1};
        tbl[8] = '{0, 125, 2, 0, 0,   1, 0, 3, 0};

        repeat (2) step();
        chk("rst.valid", blk_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.overrun", overrun, 0);
        chk("rst.error", blk_error, 0);
        chk("rst.x", blk_x, 0);
        resetn = 1'b1;
        step();
        blk_ack = 1'b1;
        step();
        blk_ack = 1'b0;
        chk("idle_ack.busy", busy, 0);
        chk("idle_ack.valid", blk_valid, 0);

        for (int t = 0; t < 9; t++) begin
            drive_block(tbl[t].ox, tbl[t].oy, tbl[t].col, tbl[t].fault, tbl[t].fidx, 0, 1'b0);
            check_block($sformatf("tbl%0d", t), tbl[t].ox, tbl[t].oy, tbl[t].col,
                        tbl[t].err, tbl[t].os, tbl[t].oe, tbl[t].on);
            accept(tbl[t].ox);
        end

        // Backpressure: dropped plots while held, then ack+plot starts next block
        drive_block(10, 5, 7, 0, 0, 0, 1'b0);
        check_block("bp", 10, 5, 7, 0, 10, 3, 1);
        for (int k = 0; k < 5; k++) begin
            plot = 1'b1; x_in = 8'($urandom); y_in = 7'($urandom); colour_in = 3'($urandom);
            step();
            chk($sformatf("bp.overrun%0d", k), overrun, 1);
            chk($sformatf("bp.hold_x%0d", k), blk_x, 10);
            chk($sformatf("bp.hold_v%0d", k), blk_valid, 1);
        end
        dx[0] = 12; dy[0] = 5; dc[0] = 7;
        plot = 1'b1; x_in = 8'd12; y_in = 7'd5; colour_in = 3'd7; blk_ack = 1'b1;
        step();
        blk_ack = 1'b0;
        pv = 1; pxv = 10;
        chk("bp.ack_overrun", overrun, 0);
        chk("bp.ack_valid", blk_valid, 0);
        chk("bp.ack_busy", busy, 1);
        drive_block(12, 5, 7, 0, 0, 1, 1'b0);
        check_block("bp_next", 12, 5, 7, 0, 12, 13, 0);
        accept(12);

        for (int r = 0; r < 25; r++) begin
            ox = ($urandom_range(0, 3) == 0) ? $urandom_range(246, 255) : $urandom_range(0, 255);
            oy = ($urandom_range(0, 3) == 0) ? $urandom_range(118, 127) : $urandom_range(0, 127);
            col = $urandom_range(0, 7);
            fault = $urandom_range(0, 3);
            fidx = $urandom_range(1, 15);
            drive_block(ox, oy, col, fault, fidx, 0, 1'b1);
            model_ovl(ox, s, e, n);
            check_block($sformatf("rnd%0d", r), ox, oy, col, model_err(ox, oy), s, e, n);
            hold = $urandom_range(0, 3);
            repeat (hold) step();
            chk($sformatf("rnd%0d.held", r), blk_valid, 1);
            accept(ox);
        end

        // Reset mid-block drops the partial block and forgets the previous one
        drive_block(100, 50, 6, 0, 0, 9, 1'b0);
        resetn = 1'b0;
        #2;
        chk("midrst.busy", busy, 0);
        chk("midrst.valid", blk_valid, 0);
        step();
        resetn = 1'b1;
        pv = 0;
        step();
        drive_block(100, 50, 6, 0, 0, 0, 1'b0);
        check_block("postrst", 100, 50, 6, 0, 100, 103, 0);
        accept(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
